// File: rtl/inst_mem_loader.sv
// inst_mem_loader
//   Boot-time writer for the instruction RAM read by the IF stage. A byte stream arriving over
//   a valid/ready handshake is packed little-endian into 32-bit words and written into an
//   internal RAM. The core stays frozen until a complete program has been loaded, after which
//   the RAM serves zero-latency instruction reads addressed by the fetch PC.
//
//   Optional build macro: LOADER_CHECKSUM_EN
//     When defined, one extra byte follows the last program word. The program is accepted only
//     if (8-bit sum of all program bytes + that byte) == 8'h00.
//
// Ports
//   clk          core clock, all state updates on the rising edge
//   rst          asynchronous active-low reset
//   ld_valid     loader byte valid
//   ld_ready     loader can accept a byte (low during reset and once RUN/ERR is reached)
//   ld_data      loader byte
//   ld_last      final program byte marker, sampled with ld_data
//   pc           fetch byte address from the IF stage
//   instruction  fetched instruction word (zero unless running and the word was loaded)
//   freeze_out   pipeline freeze, high until the program is runnable
//   load_done    program loaded, core running
//   load_err     sticky load error, core stays frozen until reset
//   word_count   number of words written since reset

module inst_mem_loader #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  input  logic [31:0]       pc,
  output logic [31:0]       instruction,
  output logic              freeze_out,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    StWait,
    StLoad,
`ifdef LOADER_CHECKSUM_EN
    StChk,
`endif
    StRun,
    StErr
  } state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH_WORDS - 1);

  state_e             r_state, w_state_d;
  logic [1:0]         r_byte_cnt, w_byte_cnt_d;
  logic [ADDR_W-1:0]  r_wr_addr, w_wr_addr_d;
  logic [ADDR_W:0]    r_word_count, w_word_count_d;
  logic [23:0]        r_shift, w_shift_d;
  logic [31:0]        r_mem [DEPTH_WORDS];

  logic               w_accept_state;
  logic               w_xfer;
  logic               w_we;
  logic [31:0]        w_wdata;
  logic [ADDR_W-1:0]  w_raddr;
  logic               w_rd_hit;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         r_sum, w_sum_d;
  logic [7:0]         w_csum;
  assign w_csum = r_sum + ld_data;
`endif

  // The handshake is decoded from state alone; reset only masks the visible ready so the
  // async reset net never enters the synchronous next-state path.
  always_comb begin
    w_accept_state = 1'b0;
    unique case (r_state)
      StWait, StLoad: w_accept_state = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      StChk:          w_accept_state = 1'b1;
`endif
      default:        w_accept_state = 1'b0;
    endcase
  end

  assign ld_ready = rst & w_accept_state;
  assign w_xfer   = ld_valid & w_accept_state;

  always_comb begin
    w_state_d      = r_state;
    w_byte_cnt_d   = r_byte_cnt;
    w_wr_addr_d    = r_wr_addr;
    w_word_count_d = r_word_count;
    w_shift_d      = r_shift;
    w_we           = 1'b0;
    // Bytes 0..2 sit in the shift register with byte 0 at the bottom.
    w_wdata        = {ld_data, r_shift};
`ifdef LOADER_CHECKSUM_EN
    w_sum_d        = r_sum;
`endif
    if (w_xfer) begin
      unique case (r_state)
        StWait, StLoad: begin
`ifdef LOADER_CHECKSUM_EN
          w_sum_d = w_csum;
`endif
          if (r_byte_cnt == 2'd3) begin
            w_we           = 1'b1;
            w_byte_cnt_d   = 2'd0;
            w_word_count_d = r_word_count + (ADDR_W+1)'(1);
            if (ld_last) begin
`ifdef LOADER_CHECKSUM_EN
              w_state_d = StChk;
`else
              w_state_d = StRun;
`endif
              w_wr_addr_d = r_wr_addr + ADDR_W'(1);
            end else if (r_wr_addr == LastAddr) begin
              // RAM full with more program pending; hold the address rather than wrap.
              w_state_d = StErr;
            end else begin
              w_state_d   = StLoad;
              w_wr_addr_d = r_wr_addr + ADDR_W'(1);
            end
          end else if (ld_last) begin
            // Truncated final word: drop the partial bytes.
            w_state_d = StErr;
          end else begin
            w_state_d    = StLoad;
            w_shift_d    = {ld_data, r_shift[23:8]};
            w_byte_cnt_d = r_byte_cnt + 2'd1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        // ld_last is ignored here; exactly one checksum byte is taken.
        StChk: w_state_d = (w_csum == 8'h00) ? StRun : StErr;
`endif
        default: w_state_d = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StWait;
      r_byte_cnt   <= 2'd0;
      r_wr_addr    <= '0;
      r_word_count <= '0;
      r_shift      <= '0;
    end else begin
      r_state      <= w_state_d;
      r_byte_cnt   <= w_byte_cnt_d;
      r_wr_addr    <= w_wr_addr_d;
      r_word_count <= w_word_count_d;
      r_shift      <= w_shift_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum <= 8'h00;
    end else begin
      r_sum <= w_sum_d;
    end
  end
`endif

  // RAM is not reset; stale words stay hidden behind the word_count gate.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_wr_addr] <= w_wdata;
    end
  end

  assign w_raddr  = pc[ADDR_W+1:2];
  assign w_rd_hit = (r_state == StRun) && (pc[31:ADDR_W+2] == '0) &&
                    ({1'b0, w_raddr} < r_word_count);

  assign instruction = w_rd_hit ? r_mem[w_raddr] : 32'h0000_0000;
  assign freeze_out  = (r_state != StRun);
  assign load_done   = (r_state == StRun);
  assign load_err    = (r_state == StErr);
  assign word_count  = r_word_count;

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  // Reference model states (WAIT and LOAD are indistinguishable at the ports).
  localparam int MLoad = 0;
  localparam int MRun  = 1;
  localparam int MErr  = 2;
  localparam int MChk  = 3;

  logic        clk;
  logic        rst;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        freeze_out;
  logic        load_done;
  logic        load_err;
  logic [AW:0] word_count;

  inst_mem_loader #(
    .DEPTH_WORDS(DEPTH),
    .ADDR_W     (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .pc         (pc),
    .instruction(instruction),
    .freeze_out (freeze_out),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int          m_state;
  int          m_count;
  int          m_nb;
  logic [31:0] m_cur;
  logic [7:0]  m_sum;
  logic [31:0] m_mem [DEPTH];
  logic [7:0]  prog_q [$];

  function automatic void model_reset();
    m_state = MLoad;
    m_count = 0;
    m_nb    = 0;
    m_cur   = 32'h0;
    m_sum   = 8'h0;
  endfunction

  function automatic bit model_ready();
    return (m_state == MLoad) || (m_state == MChk);
  endfunction

  function automatic void model_xfer(input logic [7:0] d, input logic last);
    if (m_state == MChk) begin
      m_state = (8'(m_sum + d) == 8'h00) ? MRun : MErr;
      return;
    end
    m_sum = m_sum + d;
    m_cur = m_cur | (32'(d) << (8 * m_nb));
    m_nb++;
    if (m_nb == 4) begin
      m_mem[m_count] = m_cur;
      m_count++;
      m_cur = 32'h0;
      m_nb  = 0;
      if (last) m_state = CHK_EN ? MChk : MRun;
      else if (m_count == DEPTH) m_state = MErr;
    end else if (last) begin
      m_state = MErr;
    end
  endfunction

  function automatic logic [31:0] model_instr(input logic [31:0] a);
    if (m_state != MRun) return 32'h0;
    if (64'(a) >= 64'(4 * m_count)) return 32'h0;
    return m_mem[int'(a >> 2)];
  endfunction

  // Offers one byte, optionally preceded by idle cycles carrying junk data.
  task automatic send_byte(input logic [7:0] d, input logic last, input bit gaps);
    bit          exp_rdy;
    logic [11:0] exp_st;
    logic [11:0] got_st;
    int          n;
    if (gaps) begin
      n = int'($urandom_range(0, 3));
      repeat (n) begin
        @(negedge clk);
        ld_valid = 1'b0;
        ld_data  = 8'($urandom);
        ld_last  = 1'($urandom);
        @(posedge clk);
      end
    end
    @(negedge clk);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    exp_rdy  = model_ready();
    n_vec++;
    if (ld_ready !== exp_rdy) begin
      n_err++;
      $display("FAIL ld_ready: got %b expected %b (byte %h)", ld_ready, exp_rdy, d);
    end
    @(posedge clk);
    if (exp_rdy) model_xfer(d, last);
    #1;
    exp_st = {m_state != MRun, m_state == MRun, m_state == MErr, 9'(m_count)};
    got_st = {freeze_out, load_done, load_err, word_count};
    n_vec++;
    if (got_st !== exp_st) begin
      n_err++;
      $display("FAIL status {freeze,done,err,count}: got %h expected %h", got_st, exp_st);
    end
    ld_valid = 1'b0;
  endtask

  task automatic load_prog(input bit gaps);
    logic [7:0] sum;
    sum = 8'h0;
    for (int i = 0; i < prog_q.size(); i++) begin
      sum = sum + prog_q[i];
      send_byte(prog_q[i], i == prog_q.size() - 1, gaps);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'(8'h00 - sum), 1'($urandom), gaps);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b0;
    ld_valid = 1'b0;
    pc       = 32'h0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [39:0] got;
    rst      = 1'b0;
    ld_valid = 1'b1;
    ld_data  = 8'hA5;
    ld_last  = 1'b0;
    pc       = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    got = {ld_ready, freeze_out, load_done, load_err, word_count, instruction[26:0]};
    n_vec++;
    if (got !== {1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 27'd0}) begin
      n_err++;
      $display("FAIL reset_state: got %h expected %h", got, {4'b0100, 9'd0, 27'd0});
    end
    ld_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if (ld_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_reset: got %b expected 1", ld_ready);
    end
  endtask

  task automatic test_basic(input bit gaps);
    logic [31:0] pcs [4];
    logic [31:0] exps [4];
    logic [31:0] a;
    do_reset();
    prog_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    load_prog(gaps);
    pcs  = '{32'd0, 32'd4, 32'd8, 32'd5};
    exps = '{32'h12345678, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pc = pcs[i];
      #1;
      n_vec++;
      if (instruction !== exps[i]) begin
        n_err++;
        $display("FAIL basic_read pc=%h: got %h expected %h", pcs[i], instruction, exps[i]);
      end
    end
    n_vec++;
    if (word_count !== 9'd2 || load_done !== 1'b1 || freeze_out !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done: got count=%0d done=%b freeze=%b expected 2 1 0",
               word_count, load_done, freeze_out);
    end
    for (int i = 0; i < 6; i++) begin
      a = (i < 3) ? 32'($urandom_range(0, 15)) : $urandom;
      @(negedge clk);
      pc = a;
      #1;
      n_vec++;
      if (instruction !== model_instr(a)) begin
        n_err++;
        $display("FAIL basic_rand_read pc=%h: got %h expected %h", a, instruction, model_instr(a));
      end
    end
  endtask

  task automatic test_random_program();
    int          nw;
    logic [31:0] a;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      nw = int'($urandom_range(1, 32));
      prog_q.delete();
      for (int i = 0; i < 4 * nw; i++) prog_q.push_back(8'($urandom));
      load_prog(1'b1);
      for (int i = 0; i < 16; i++) begin
        a = (i < 14) ? 32'($urandom_range(0, 4 * nw + 12)) : $urandom;
        @(negedge clk);
        pc = a;
        #1;
        n_vec++;
        if (instruction !== model_instr(a)) begin
          n_err++;
          $display("FAIL rand_read pc=%h: got %h expected %h", a, instruction, model_instr(a));
        end
      end
    end
  endtask

  task automatic test_truncated();
    logic [31:0] a;
    do_reset();
    prog_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    for (int i = 0; i < 7; i++) send_byte(prog_q[i], i == 6, 1'b1);
    n_vec++;
    if ({load_err, freeze_out, ld_ready, word_count} !== {3'b110, 9'd1}) begin
      n_err++;
      $display("FAIL truncated: got err=%b freeze=%b ready=%b count=%0d expected 1 1 0 1",
               load_err, freeze_out, ld_ready, word_count);
    end
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 32'h0 : $urandom;
      @(negedge clk);
      pc = a;
      #1;
      n_vec++;
      if (instruction !== 32'h0) begin
        n_err++;
        $display("FAIL truncated_read pc=%h: got %h expected 0", a, instruction);
      end
    end
    send_byte(8'hAA, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4 * DEPTH; i++) send_byte(8'($urandom), 1'b0, 1'b0);
    n_vec++;
    if (load_err !== 1'b1 || word_count !== 9'd256 || ld_ready !== 1'b0) begin
      n_err++;
      $display("FAIL overflow: got err=%b count=%0d ready=%b expected 1 256 0",
               load_err, word_count, ld_ready);
    end
    send_byte(8'h5A, 1'b0, 1'b0);
    send_byte(8'h5B, 1'b1, 1'b0);
  endtask

  task automatic test_reset_midload();
    logic [31:0] pcs [3];
    logic [31:0] exps [3];
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(8'(8'h90 + i), 1'b0, 1'b0);
    // Asynchronous reset in the middle of a clock phase.
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if ({ld_ready, freeze_out, load_done, load_err, word_count} !== {4'b0100, 9'd0}) begin
      n_err++;
      $display("FAIL midload_reset: got ready=%b freeze=%b done=%b err=%b count=%0d",
               ld_ready, freeze_out, load_done, load_err, word_count);
    end
    @(negedge clk);
    rst = 1'b1;
    prog_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    load_prog(1'b0);
    pcs  = '{32'd0, 32'd4, 32'd8};
    exps = '{32'h44332211, 32'h0, 32'h0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pc = pcs[i];
      #1;
      n_vec++;
      if (instruction !== exps[i]) begin
        n_err++;
        $display("FAIL midload_read pc=%h: got %h expected %h", pcs[i], instruction, exps[i]);
      end
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] csum [2];
    csum = '{8'hFF, 8'hFE};
    for (int k = 0; k < 2; k++) begin
      do_reset();
      send_byte(8'h01, 1'b0, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      send_byte(8'h00, 1'b1, 1'b0);
      n_vec++;
      if (ld_ready !== 1'b1 || freeze_out !== 1'b1) begin
        n_err++;
        $display("FAIL chk_wait: got ready=%b freeze=%b expected 1 1", ld_ready, freeze_out);
      end
      send_byte(csum[k], 1'b1, 1'b0);
      pc = 32'h0;
      #1;
      n_vec++;
      if ({load_done, load_err} !== ((k == 0) ? 2'b10 : 2'b01) ||
          instruction !== ((k == 0) ? 32'h1 : 32'h0)) begin
        n_err++;
        $display("FAIL checksum %h: got done=%b err=%b instr=%h", csum[k], load_done, load_err,
                 instruction);
      end
    end
  endtask
`endif

  initial begin
    ld_valid = 1'b0;
    ld_data  = 8'h0;
    ld_last  = 1'b0;
    rst      = 1'b0;
    pc       = 32'h0;
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_random_program();
    test_truncated();
    test_overflow();
    test_reset_midload();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
